// File: rtl/varredura_display.sv
// Four-digit multiplexed seven-segment scan driver (PC tens/units, register tens/units).
// All four digits are snapshotted once per frame so a frame never mixes old and new values.
module varredura_display #(
    parameter int DIV_CICLOS   = 50000,
    parameter int BLANK_CICLOS = 2,
    parameter bit ATIVO_BAIXO  = 1'b1,
    parameter bit APAGA_ZERO   = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dezenapc,
    input  logic [3:0] unidadepc,
    input  logic [3:0] dezenareg,
    input  logic [3:0] unidadereg,
    output logic [3:0] anodo,
    output logic [6:0] segmentos
);
    localparam int CW = $clog2(DIV_CICLOS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV_CICLOS - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CICLOS);
    localparam logic [3:0]    ANODO_OFF = ATIVO_BAIXO ? 4'hF : 4'h0;
    localparam logic [6:0]    SEG_OFF   = ATIVO_BAIXO ? 7'h7F : 7'h00;

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [3:0]    h0, h1, h2, h3;
    logic [3:0]    digito;
    logic [3:0]    anodo_ah;
    logic [6:0]    seg_ah;
    logic [3:0]    anodo_nxt;
    logic [6:0]    seg_nxt;
    logic          apagado;

    // Active-high {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        digito = h0;
        case (dig)
            2'd1:    digito = h1;
            2'd2:    digito = h2;
            2'd3:    digito = h3;
            default: digito = h0;
        endcase
    end

    // Odd slots carry the tens digits; only those are eligible for zero blanking.
    always_comb begin
        anodo_ah = 4'b0000;
        seg_ah   = 7'b0000000;
        apagado  = (cnt < CNT_BLANK) || (APAGA_ZERO && dig[0] && (digito == 4'd0));
        if (!apagado) begin
            anodo_ah = 4'b0001 << dig;
            seg_ah   = decode(digito);
        end
        anodo_nxt = ATIVO_BAIXO ? ~anodo_ah : anodo_ah;
        seg_nxt   = ATIVO_BAIXO ? ~seg_ah : seg_ah;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            dig       <= 2'd0;
            h0        <= 4'd0;
            h1        <= 4'd0;
            h2        <= 4'd0;
            h3        <= 4'd0;
            anodo     <= ANODO_OFF;
            segmentos <= SEG_OFF;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                dig <= dig + 2'd1;
                if (dig == 2'd3) begin
                    h0 <= unidadereg;
                    h1 <= dezenareg;
                    h2 <= unidadepc;
                    h3 <= dezenapc;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
            anodo     <= anodo_nxt;
            segmentos <= seg_nxt;
        end
    end
endmodule
